counter_serial_rx: RTL and testbench

Serial receiver for the counter's `serial_out`/`serial_enable` stream. It deserializes WIDTH-bit frames, MSB first, into parallel words and flags frames that end early. It also checks that consecutive received words differ by a programmed step, so a bench or downstream logic can monitor the counter through its one-wire output. It sits on the same clock as the counter, directly at the far end of the serial link.

---
 rtl/counter_serial_rx.sv | 129 ++++++++++++
 tb/tb_counter_serial_rx.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/counter_serial_rx.sv
// Serial receiver for the counter's one-wire output: deserializes MSB-first
// WIDTH-bit frames, flags aborted frames and checks the step between words.
module counter_serial_rx #(
  parameter int WIDTH     = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 serial_enable,
  input  logic                 serial_in,
  input  logic                 check_en,
  input  logic [WIDTH-1:0]     expected_step,
  output logic [WIDTH-1:0]     rx_data,
  output logic                 rx_valid,
  output logic                 frame_error,
  output logic                 step_error,
  output logic [CNT_WIDTH-1:0] frame_count,
  output logic [CNT_WIDTH-1:0] error_count,
  output logic                 busy
);

  localparam int BW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0]        LAST    = BW'(WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic {IDLE, SHIFT} state_t;

  typedef struct packed {
    logic vld;
    logic ferr;
    logic serr;
  } rx_evt_t;

  state_t         state, state_d;
  logic [BW-1:0]  bit_cnt, bit_cnt_d;
  logic [WIDTH-1:0] shreg, shreg_d;
  logic [WIDTH-1:0] prev, prev_d;
  logic [WIDTH-1:0] rx_data_d;
  logic [WIDTH-1:0] word, delta;
  logic           have_prev, have_prev_d;
  rx_evt_t        evt_d;
  logic [CNT_WIDTH-1:0] frame_count_d, error_count_d;

  // Word as it would look once the current serial bit is shifted in.
  assign word  = {shreg[WIDTH-2:0], serial_in};
  assign delta = word - prev;

  always_comb begin
    state_d       = state;
    bit_cnt_d     = bit_cnt;
    shreg_d       = shreg;
    prev_d        = prev;
    have_prev_d   = have_prev;
    rx_data_d     = rx_data;
    evt_d         = '0;
    frame_count_d = frame_count;
    error_count_d = error_count;

    case (state)
      IDLE: begin
        if (serial_enable) begin
          shreg_d   = WIDTH'(serial_in);
          bit_cnt_d = BW'(1);
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (serial_enable) begin
          shreg_d = word;
          if (bit_cnt == LAST) begin
            rx_data_d   = word;
            evt_d.vld   = 1'b1;
            evt_d.serr  = check_en && have_prev && (delta != expected_step);
            prev_d      = word;
            have_prev_d = 1'b1;
            bit_cnt_d   = '0;
          end else begin
            bit_cnt_d = bit_cnt + 1'b1;
          end
        end else begin
          // Dropping enable at a frame boundary is a normal end of stream.
          if (bit_cnt != '0) begin
            evt_d.ferr  = 1'b1;
            have_prev_d = 1'b0;
          end
          bit_cnt_d = '0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (evt_d.vld && (frame_count != CNT_MAX))
      frame_count_d = frame_count + 1'b1;
    if ((evt_d.ferr || evt_d.serr) && (error_count != CNT_MAX))
      error_count_d = error_count + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      prev        <= '0;
      have_prev   <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_error <= 1'b0;
      step_error  <= 1'b0;
      frame_count <= '0;
      error_count <= '0;
      busy        <= 1'b0;
    end else begin
      state       <= state_d;
      bit_cnt     <= bit_cnt_d;
      shreg       <= shreg_d;
      prev        <= prev_d;
      have_prev   <= have_prev_d;
      rx_data     <= rx_data_d;
      rx_valid    <= evt_d.vld;
      frame_error <= evt_d.ferr;
      step_error  <= evt_d.serr;
      frame_count <= frame_count_d;
      error_count <= error_count_d;
      busy        <= (bit_cnt_d != '0);
    end
  end

endmodule

// File: tb/tb_counter_serial_rx.sv
// Randomized scoreboard bench for counter_serial_rx: bursts of words are
// modelled per burst and checked against the DUT's output pulses.
module tb_counter_serial_rx;

  localparam int W    = 4;
  localparam int CW   = 5;
  localparam int CMAX = (1 << CW) - 1;
  localparam int MOD  = 1 << W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          serial_enable = 1'b0;
  logic          serial_in = 1'b0;
  logic          check_en = 1'b0;
  logic [W-1:0]  expected_step = '0;
  logic [W-1:0]  rx_data;
  logic          rx_valid, frame_error, step_error, busy;
  logic [CW-1:0] frame_count, error_count;

  counter_serial_rx #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .serial_enable(serial_enable),
    .serial_in(serial_in), .check_en(check_en), .expected_step(expected_step),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_error(frame_error),
    .step_error(step_error), .frame_count(frame_count),
    .error_count(error_count), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit       ferr;
    int       data;
    bit       serr;
    int       fc;
    int       ec;
    int       cyc;
  } evt_t;

  evt_t q[$];
  int   wq[$];

  // Reference state
  int m_fc, m_ec, m_prev, m_data;
  bit m_have;
  int run_len;

  int n_chk = 0;
  int n_fail = 0;

  function automatic void chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void model_word(input int w, input bit ce, input int step, input int e);
    evt_t ev;
    int d;
    d = (w - m_prev + MOD) % MOD;
    ev.ferr = 1'b0;
    ev.serr = ce && m_have && (d != step);
    m_prev = w;
    m_have = 1'b1;
    m_data = w;
    if (m_fc < CMAX) m_fc++;
    if (ev.serr && m_ec < CMAX) m_ec++;
    ev.data = w;
    ev.fc = m_fc;
    ev.ec = m_ec;
    ev.cyc = e;
    q.push_back(ev);
  endfunction

  function automatic void model_abort(input int e);
    evt_t ev;
    m_have = 1'b0;
    if (m_ec < CMAX) m_ec++;
    ev.ferr = 1'b1;
    ev.serr = 1'b0;
    ev.data = m_data;
    ev.fc = m_fc;
    ev.ec = m_ec;
    ev.cyc = e;
    q.push_back(ev);
  endfunction

  // Drive one serial cycle; e is the clock edge that will sample it.
  task automatic drive(input bit se, input bit si, output int e);
    @(negedge clk);
    chk("busy", int'(busy), int'((run_len % W) != 0));
    serial_enable = se;
    serial_in = si;
    e = cyc + 1;
    run_len = se ? run_len + 1 : 0;
  endtask

  // Sends the words in wq back-to-back, then 'extra' partial bits, then a gap.
  task automatic send_burst(input int extra, input bit ce, input int step, input int gap);
    int e;
    logic [W-1:0] w;
    check_en = ce;
    expected_step = W'(step);
    foreach (wq[i]) begin
      w = W'(wq[i]);
      for (int b = W - 1; b >= 0; b--) begin
        drive(1'b1, w[b], e);
        if (b == 0) model_word(wq[i], ce, step, e);
      end
    end
    for (int b = 0; b < extra; b++) drive(1'b1, 1'($urandom), e);
    for (int g = 0; g < gap; g++) begin
      drive(1'b0, 1'b0, e);
      if (g == 0 && extra > 0) model_abort(e);
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n = 1'b0;
    serial_enable = 1'b0;
    for (int i = 0; i < n; i++) begin
      serial_in = ~serial_in;
      @(negedge clk);
    end
    rst_n = 1'b1;
    serial_in = 1'b0;
    q.delete();
    m_fc = 0; m_ec = 0; m_prev = 0; m_data = 0; m_have = 1'b0; run_len = 0;
    chk("rst_rx_data", int'(rx_data), 0);
    chk("rst_rx_valid", int'(rx_valid), 0);
    chk("rst_frame_error", int'(frame_error), 0);
    chk("rst_step_error", int'(step_error), 0);
    chk("rst_frame_count", int'(frame_count), 0);
    chk("rst_error_count", int'(error_count), 0);
    chk("rst_busy", int'(busy), 0);
  endtask

  // Monitor: every output pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      evt_t ev;
      chk("step_error_without_valid", int'(step_error & ~rx_valid), 0);
      while (q.size() > 0 && q[0].cyc < cyc) begin
        n_chk++;
        n_fail++;
        $display("FAIL missed_event: no pulse seen, expected at cycle %0d (now %0d)", q[0].cyc, cyc);
        void'(q.pop_front());
      end
      if (rx_valid || frame_error) begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_pulse: rx_valid=%0d frame_error=%0d, expected none (cycle %0d)",
                   rx_valid, frame_error, cyc);
        end else begin
          ev = q.pop_front();
          chk("event_cycle", cyc, ev.cyc);
          chk("frame_error", int'(frame_error), int'(ev.ferr));
          chk("rx_valid", int'(rx_valid), int'(!ev.ferr));
          chk("rx_data", int'(rx_data), ev.data);
          chk("step_error", int'(step_error), int'(ev.serr));
          chk("frame_count", int'(frame_count), ev.fc);
          chk("error_count", int'(error_count), ev.ec);
        end
      end
    end
  end

  initial begin
    int nw, extra, step, w, gap;
    bit ce;

    do_reset(2);

    wq = '{11};
    send_burst(0, 1'b0, 0, 2);

    do_reset(2);
    wq = '{1, 3, 5, 7, 9, 11, 13, 15, 1};
    send_burst(0, 1'b1, 2, 2);

    do_reset(2);
    wq = '{4, 6, 9};
    send_burst(0, 1'b1, 2, 2);
    send_burst(0, 1'b0, 2, 2);

    // Aborted frame, then have_prev must be cleared.
    wq.delete();
    send_burst(2, 1'b1, 2, 3);
    wq = '{8, 10};
    send_burst(0, 1'b1, 2, 2);

    // Reset two bits into a frame.
    begin
      int e;
      drive(1'b1, 1'b1, e);
      drive(1'b1, 1'b0, e);
    end
    do_reset(1);
    wq = '{5};
    send_burst(0, 1'b1, 2, 2);

    // Random bursts; long enough to saturate both counters.
    for (int n = 0; n < 120; n++) begin
      nw    = $urandom_range(0, 4);
      extra = ($urandom_range(0, 3) == 0) ? $urandom_range(1, W - 1) : 0;
      if (nw == 0 && extra == 0) nw = 1;
      step  = $urandom_range(0, MOD - 1);
      ce    = 1'($urandom);
      gap   = $urandom_range(1, 3);
      w     = $urandom_range(0, MOD - 1);
      wq.delete();
      for (int i = 0; i < nw; i++) begin
        wq.push_back(w);
        w = ($urandom_range(0, 2) != 0) ? (w + step) % MOD : $urandom_range(0, MOD - 1);
      end
      send_burst(extra, ce, step, gap);
    end

    repeat (8) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    chk("final_frame_count", int'(frame_count), m_fc);
    chk("final_error_count", int'(error_count), m_ec);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
